// File: rtl/cpu_pkg.sv
// Shared definitions for the core's control blocks.
//   ADDR_W / DATA_W   : data-memory address and data widths.
//   RESET_VEC_ADDR    : memory cell holding the reset vector.
//   INTR_VEC_ADDR     : memory cell holding the interrupt vector.
//   seq_state_t       : states of the PC vector sequencer.
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] RESET_VEC_ADDR = 8'h00;
    localparam logic [ADDR_W-1:0] INTR_VEC_ADDR  = 8'h01;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        PUSH     = 3'd1,
        VEC_RD   = 3'd2,
        VEC_WAIT = 3'd3,
        LOAD     = 3'd4
    } seq_state_t;

endpackage

// File: rtl/intr_pending_latch.sv
// Interrupt request latch.
// Registers intr_in, detects its 0->1 edge and holds a pending flag until
// the sequencer services it.
//   clk, rst   : clock, synchronous active-high reset.
//   intr_in    : raw interrupt request level.
//   flush      : drop any pending request (external reset request).
//   clear      : request serviced this cycle.
//   pending    : an interrupt edge has been seen and not yet serviced.
// Priority: flush > new edge > clear, so an edge arriving in the service
// cycle is not lost.
module intr_pending_latch
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic intr_in,
    input  logic flush,
    input  logic clear,
    output logic pending
);

    logic intr_q;
    logic intr_rise;

    assign intr_rise = intr_in & ~intr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            intr_q  <= 1'b0;
            pending <= 1'b0;
        end else begin
            intr_q <= intr_in;
            if (flush) begin
                pending <= 1'b0;
            end else if (intr_rise) begin
                pending <= 1'b1;
            end else if (clear) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pc_vector_sequencer.sv
// PC vector sequencer.
// Takes the data-memory port away from the core to fetch the reset vector
// (after rst or reset_in) or, on interrupt entry, to push the return PC and
// fetch the interrupt vector; then pulses pc_load with the fetched vector.
//   clk, rst        : clock, synchronous active-high reset.
//   reset_in        : external reset request (level), highest priority.
//   intr_in         : interrupt request, rising edge latched.
//   intr_enable     : global interrupt enable.
//   instr_boundary  : core may be interrupted this cycle.
//   pc_cur, sp_cur  : return address and stack pointer for the push.
//   mem_rdata       : data-memory read data (MEM_RD_LATENCY cycles after mem_rd).
//   seq_owns_mem    : memory mux select, 1 = sequencer drives the port.
//   mem_addr/rd/wr/wdata : memory port.
//   pc_load, pc_load_val : load pulse and vector for the PC.
//   sp_dec          : decrement SP (paired with the push write).
//   intr_disable, intr_ack : interrupt entry completed.
//   core_stall      : hold fetch/decode.
//   state_dbg       : current FSM state.
// MEM_RD_LATENCY must lie in 1..4.
module pc_vector_sequencer #(
    parameter logic [cpu_pkg::ADDR_W-1:0] RESET_VEC_ADDR = cpu_pkg::RESET_VEC_ADDR,
    parameter logic [cpu_pkg::ADDR_W-1:0] INTR_VEC_ADDR  = cpu_pkg::INTR_VEC_ADDR,
    parameter int                         MEM_RD_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         reset_in,
    input  logic                         intr_in,
    input  logic                         intr_enable,
    input  logic                         instr_boundary,
    input  logic [cpu_pkg::ADDR_W-1:0]   pc_cur,
    input  logic [cpu_pkg::ADDR_W-1:0]   sp_cur,
    input  logic [cpu_pkg::DATA_W-1:0]   mem_rdata,
    output logic                         seq_owns_mem,
    output logic [cpu_pkg::ADDR_W-1:0]   mem_addr,
    output logic                         mem_rd,
    output logic                         mem_wr,
    output logic [cpu_pkg::DATA_W-1:0]   mem_wdata,
    output logic                         pc_load,
    output logic [cpu_pkg::ADDR_W-1:0]   pc_load_val,
    output logic                         sp_dec,
    output logic                         intr_disable,
    output logic                         intr_ack,
    output logic                         core_stall,
    output cpu_pkg::seq_state_t          state_dbg
);

    import cpu_pkg::*;

    localparam logic [1:0] WAIT_INIT = 2'(MEM_RD_LATENCY - 1);

    seq_state_t          state, state_next;
    logic                vsel, vsel_next;     // 0 = reset vector, 1 = interrupt vector
    logic [1:0]          wait_cnt;
    logic [DATA_W-1:0]   vec_q;
    logic                pending;
    logic                pending_clear;

    // Servicing completes in the LOAD cycle of an interrupt sequence.
    assign pending_clear = (state == LOAD) && vsel;

    intr_pending_latch u_pending (
        .clk     (clk),
        .rst     (rst),
        .intr_in (intr_in),
        .flush   (reset_in),
        .clear   (pending_clear),
        .pending (pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= VEC_RD;
            vsel     <= 1'b0;
            wait_cnt <= 2'd0;
            vec_q    <= '0;
        end else begin
            state <= state_next;
            vsel  <= vsel_next;
            if (state == VEC_RD) begin
                wait_cnt <= WAIT_INIT;
            end else if ((state == VEC_WAIT) && (wait_cnt != 2'd0)) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
            if ((state == VEC_WAIT) && (wait_cnt == 2'd0)) begin
                vec_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        vsel_next  = vsel;
        case (state)
            RUN: begin
                if (pending && intr_enable && instr_boundary) begin
                    state_next = PUSH;
                    vsel_next  = 1'b1;
                end
            end
            PUSH:     state_next = VEC_RD;
            VEC_RD:   state_next = VEC_WAIT;
            VEC_WAIT: begin
                if (wait_cnt == 2'd0) begin
                    state_next = LOAD;
                end
            end
            LOAD:     state_next = RUN;
            default: begin
                state_next = VEC_RD;
                vsel_next  = 1'b0;
            end
        endcase
        // An external reset request overrides whatever was in progress.
        if (reset_in) begin
            state_next = VEC_RD;
            vsel_next  = 1'b0;
        end
    end

    // Outputs decode the state; while rst is held every strobe is forced
    // low so nothing reaches memory or the PC before reset is released.
    always_comb begin
        core_stall   = rst || (state != RUN);
        seq_owns_mem = core_stall;
        mem_addr     = RESET_VEC_ADDR;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_wdata    = '0;
        pc_load      = 1'b0;
        pc_load_val  = vec_q;
        sp_dec       = 1'b0;
        intr_disable = 1'b0;
        intr_ack     = 1'b0;
        if (!rst) begin
            case (state)
                PUSH: begin
                    mem_addr  = sp_cur;
                    mem_wr    = 1'b1;
                    mem_wdata = pc_cur;
                    sp_dec    = 1'b1;
                end
                VEC_RD: begin
                    mem_addr = vsel ? INTR_VEC_ADDR : RESET_VEC_ADDR;
                    mem_rd   = 1'b1;
                end
                VEC_WAIT: begin
                    mem_addr = vsel ? INTR_VEC_ADDR : RESET_VEC_ADDR;
                end
                LOAD: begin
                    pc_load      = 1'b1;
                    intr_ack     = vsel;
                    intr_disable = vsel;
                end
                default: ;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_pc_vector_sequencer.sv
// Bench for pc_vector_sequencer: two instances (read latency 1 and 3) share
// all stimulus. Expected memory/PC transactions, stamped with the cycle they
// must appear in, are pushed per instance when a scenario is issued; a
// negedge monitor per instance pops and compares every strobe it sees and
// checks core_stall against the expected busy windows.
module tb_pc_vector_sequencer;
    import cpu_pkg::*;

    localparam int W    = 38;   // {cycle[15:0], wr, rd, ld, spd, ack, dis, addr, data}
    localparam int NCYC = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst, reset_in, intr_in, intr_enable, instr_boundary;
    logic [7:0] pc_cur, sp_cur;
    logic [7:0] mem [0:255];

    logic [7:0] rdata_a, addr_a, wdata_a, lval_a;
    logic       own_a, rd_a, wr_a, ld_a, spd_a, dis_a, ack_a, stall_a;
    seq_state_t st_a;
    logic [7:0] rdata_b, addr_b, wdata_b, lval_b;
    logic       own_b, rd_b, wr_b, ld_b, spd_b, dis_b, ack_b, stall_b;
    seq_state_t st_b;

    pc_vector_sequencer #(.MEM_RD_LATENCY(1)) u_dut_a (
        .clk(clk), .rst(rst), .reset_in(reset_in), .intr_in(intr_in),
        .intr_enable(intr_enable), .instr_boundary(instr_boundary),
        .pc_cur(pc_cur), .sp_cur(sp_cur), .mem_rdata(rdata_a),
        .seq_owns_mem(own_a), .mem_addr(addr_a), .mem_rd(rd_a), .mem_wr(wr_a),
        .mem_wdata(wdata_a), .pc_load(ld_a), .pc_load_val(lval_a), .sp_dec(spd_a),
        .intr_disable(dis_a), .intr_ack(ack_a), .core_stall(stall_a), .state_dbg(st_a)
    );

    pc_vector_sequencer #(.MEM_RD_LATENCY(3)) u_dut_b (
        .clk(clk), .rst(rst), .reset_in(reset_in), .intr_in(intr_in),
        .intr_enable(intr_enable), .instr_boundary(instr_boundary),
        .pc_cur(pc_cur), .sp_cur(sp_cur), .mem_rdata(rdata_b),
        .seq_owns_mem(own_b), .mem_addr(addr_b), .mem_rd(rd_b), .mem_wr(wr_b),
        .mem_wdata(wdata_b), .pc_load(ld_b), .pc_load_val(lval_b), .sp_dec(spd_b),
        .intr_disable(dis_b), .intr_ack(ack_b), .core_stall(stall_b), .state_dbg(st_b)
    );

    // Memory read model: data appears LATENCY cycles after mem_rd, random
    // junk otherwise so an early capture is visible.
    logic [7:0] pipe_a [0:3];
    logic [7:0] pipe_b [0:3];
    always @(posedge clk) begin
        pipe_a[0] <= rd_a ? mem[addr_a] : 8'($urandom);
        pipe_b[0] <= rd_b ? mem[addr_b] : 8'($urandom);
        for (int i = 1; i < 4; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end
    assign rdata_a = pipe_a[0];
    assign rdata_b = pipe_b[2];

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q_a[$];
    logic [W-1:0] exp_q_b[$];
    bit           busy_a [NCYC];
    bit           busy_b [NCYC];
    int           checks   = 0;
    int           failures = 0;

    localparam logic [5:0] F_WR    = 6'b100100;
    localparam logic [5:0] F_RD    = 6'b010000;
    localparam logic [5:0] F_LD    = 6'b001000;
    localparam logic [5:0] F_LD_IN = 6'b001011;

    function automatic logic [W-1:0] ev(input int t, input logic [5:0] f,
                                        input logic [7:0] a, input logic [7:0] d);
        logic [15:0] t16;
        t16 = t[15:0];
        return {t16, f, a, d};
    endfunction

    task automatic exp_push(input int lat, input logic [W-1:0] e);
        if (lat == 1) exp_q_a.push_back(e);
        else          exp_q_b.push_back(e);
    endtask

    task automatic mark_busy(input int lat, input int from, input int to);
        for (int c = from; c <= to; c++) begin
            if (lat == 1) busy_a[c] = 1'b1;
            else          busy_b[c] = 1'b1;
        end
    endtask

    // Reset-vector fetch whose VEC_RD cycle is c0.
    task automatic model_reset_fetch(input int c0);
        for (int k = 0; k < 2; k++) begin
            automatic int lat = (k == 0) ? 1 : 3;
            exp_push(lat, ev(c0, F_RD, RESET_VEC_ADDR, 8'h00));
            exp_push(lat, ev(c0 + lat + 1, F_LD, 8'h00, mem[0]));
            mark_busy(lat, c0, c0 + lat + 1);
        end
    endtask

    // Interrupt accepted at cycle t; if aborted, only push and read happen.
    task automatic model_intr(input int t, input logic [7:0] pc, input logic [7:0] sp,
                              input bit aborted);
        for (int k = 0; k < 2; k++) begin
            automatic int lat = (k == 0) ? 1 : 3;
            exp_push(lat, ev(t + 1, F_WR, sp, pc));
            exp_push(lat, ev(t + 2, F_RD, INTR_VEC_ADDR, 8'h00));
            if (aborted) begin
                mark_busy(lat, t + 1, t + 3);
            end else begin
                exp_push(lat, ev(t + 3 + lat, F_LD_IN, 8'h00, mem[1]));
                mark_busy(lat, t + 1, t + 3 + lat);
            end
        end
    endtask

    task automatic check_dut(input int lat, input logic wr, input logic rd, input logic ld,
                             input logic spd, input logic ack, input logic dis,
                             input logic [7:0] addr, input logic [7:0] wdata,
                             input logic [7:0] lval, input logic stall, input logic own,
                             input seq_state_t st);
        logic [W-1:0] act;
        logic [W-1:0] want;
        bit           busy;
        if (cyc < 1 || cyc >= NCYC) return;
        busy = (lat == 1) ? busy_a[cyc] : busy_b[cyc];
        checks++;
        if (stall !== busy || own !== busy) begin
            failures++;
            $display("FAIL stall lat=%0d cyc=%0d state=%0d got stall=%b own=%b want=%b",
                     lat, cyc, st, stall, own, busy);
        end
        if ((wr | rd | ld | spd | ack | dis) !== 1'b0) begin
            act = {cyc[15:0], wr, rd, ld, spd, ack, dis,
                   (wr | rd) ? addr : 8'h00, wr ? wdata : (ld ? lval : 8'h00)};
            checks++;
            if ((lat == 1 && exp_q_a.size() == 0) || (lat == 3 && exp_q_b.size() == 0)) begin
                failures++;
                $display("FAIL unexpected_strobe lat=%0d cyc=%0d state=%0d got=%h want=none",
                         lat, cyc, st, act);
            end else begin
                want = (lat == 1) ? exp_q_a.pop_front() : exp_q_b.pop_front();
                if (act !== want) begin
                    failures++;
                    $display("FAIL transaction lat=%0d cyc=%0d state=%0d got=%h want=%h",
                             lat, cyc, st, act, want);
                end
            end
        end
    endtask

    always @(negedge clk)
        check_dut(1, wr_a, rd_a, ld_a, spd_a, ack_a, dis_a, addr_a, wdata_a, lval_a,
                  stall_a, own_a, st_a);
    always @(negedge clk)
        check_dut(3, wr_b, rd_b, ld_b, spd_b, ack_b, dis_b, addr_b, wdata_b, lval_b,
                  stall_b, own_b, st_b);

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: interrupt, 1: masked then enabled, 2: reset_in during VEC_WAIT,
    // 3: reset_in in the accept cycle, 4: reset_in while running.
    task automatic scenario(input int mode, input logic [7:0] pc, input logic [7:0] sp);
        int t;
        intr_in        = 1'b0;
        instr_boundary = 1'b0;
        intr_enable    = (mode != 1);
        tick();
        if (mode != 4) intr_in = 1'b1;
        if (mode == 1) begin
            instr_boundary = 1'b1;   // boundary present but interrupts masked
            tick(); tick(); tick();
        end else begin
            tick(); tick();
        end
        pc_cur         = pc;
        sp_cur         = sp;
        intr_enable    = 1'b1;
        instr_boundary = (mode != 4);
        reset_in       = (mode == 3 || mode == 4);
        t              = cyc;
        case (mode)
            2:       begin model_intr(t, pc, sp, 1'b1); model_reset_fetch(t + 4); end
            3, 4:    model_reset_fetch(t + 1);
            default: model_intr(t, pc, sp, 1'b0);
        endcase
        tick();
        instr_boundary = 1'b0;
        reset_in       = 1'b0;
        intr_in        = 1'b0;
        if (mode == 2) begin
            tick(); tick();
            reset_in = 1'b1;
            tick();
            reset_in = 1'b0;
        end
        repeat (10) tick();
        // Nothing may be left pending: a boundary with interrupts enabled
        // must not start another sequence.
        instr_boundary = 1'b1;
        repeat (3) tick();
        instr_boundary = 1'b0;
        tick();
    endtask

    function automatic logic [7:0] pick_vec();
        int r;
        r = $urandom_range(0, 5);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'hFF;
        return 8'($urandom);
    endfunction

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        summary();
        $finish;
    end

    initial begin
        int c0;
        rst = 1'b1; reset_in = 1'b0; intr_in = 1'b0; intr_enable = 1'b0;
        instr_boundary = 1'b0; pc_cur = 8'h00; sp_cur = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h20;
        mem[1] = 8'h80;
        mark_busy(1, 0, 2);
        mark_busy(3, 0, 2);

        tick();
        @(negedge clk);
        checks++;
        if (addr_a !== RESET_VEC_ADDR || addr_b !== RESET_VEC_ADDR) begin
            failures++;
            $display("FAIL reset_addr got=%h/%h want=%h", addr_a, addr_b, RESET_VEC_ADDR);
        end
        tick();
        tick();
        rst = 1'b0;
        c0  = cyc;
        model_reset_fetch(c0);
        repeat (10) tick();

        scenario(0, 8'h35, 8'hFF);  // plain interrupt entry
        scenario(1, 8'h47, 8'h80);  // masked, then enabled at a boundary
        scenario(2, 8'h12, 8'h40);  // reset request during vector wait
        scenario(3, 8'h66, 8'h20);  // reset request collides with accept
        scenario(4, 8'h00, 8'h00);  // reset request while running

        repeat (16) begin
            mem[0] = pick_vec();
            mem[1] = pick_vec();
            scenario($urandom_range(0, 4), 8'($urandom), 8'($urandom));
        end

        repeat (5) tick();
        checks++;
        if (exp_q_a.size() != 0) begin
            failures++;
            $display("FAIL missing_lat1 got=%0d_outstanding want=0", exp_q_a.size());
        end
        checks++;
        if (exp_q_b.size() != 0) begin
            failures++;
            $display("FAIL missing_lat3 got=%0d_outstanding want=0", exp_q_b.size());
        end
        summary();
        $finish;
    end

endmodule
